// File: rtl/soc_wb_pkg.sv
// Shared Wishbone definitions: bridge FSM states, cycle-type constants, counter sizing.
package soc_wb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP} wb_bridge_state_t;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_EOB     = 3'b111;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

  // Counter width able to hold TIMEOUT, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/soc_wb_timeout_bridge_if.sv
// Single Wishbone link: master modport drives the request, slave modport returns the response.
interface soc_wb_timeout_bridge_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH >> 3;

  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] wdat;
  logic [DATA_WIDTH-1:0] rdat;
  logic [SEL_WIDTH-1:0]  sel;
  logic                  we;
  logic                  cyc;
  logic                  stb;
  logic [2:0]            cti;
  logic [1:0]            bte;
  logic                  ack;
  logic                  err;
  logic                  rty;

  modport master (
    output adr, wdat, sel, we, cyc, stb, cti, bte,
    input  rdat, ack, err, rty
  );

  modport slave (
    input  adr, wdat, sel, we, cyc, stb, cti, bte,
    output rdat, ack, err, rty
  );

endinterface

// File: rtl/soc_wb_watchdog_cnt.sv
// Saturating cycle counter for the bus watchdog; expired flags the last allowed REQ cycle.
module soc_wb_watchdog_cnt
  import soc_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_WIDTH = cnt_width(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT  = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (TIMEOUT != 0) && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/soc_wb_timeout_bridge.sv
// Registered single-beat Wishbone bridge that terminates unanswered cycles with an error.
module soc_wb_timeout_bridge
  import soc_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  soc_wb_timeout_bridge_if.slave  m,
  soc_wb_timeout_bridge_if.master s,
  output logic                  timeout_o,
  output logic [ADDR_WIDTH-1:0] timeout_adr_o
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH >> 3;

  wb_bridge_state_t      state_q, state_d;
  logic [ADDR_WIDTH-1:0] s_adr_q, s_adr_d;
  logic [DATA_WIDTH-1:0] s_dat_q, s_dat_d;
  logic [SEL_WIDTH-1:0]  s_sel_q, s_sel_d;
  logic                  s_we_q, s_we_d;
  logic                  s_req_q, s_req_d;
  logic [DATA_WIDTH-1:0] m_dat_q, m_dat_d;
  logic                  m_ack_q, m_ack_d;
  logic                  m_err_q, m_err_d;
  logic                  m_rty_q, m_rty_d;
  logic                  timeout_q, timeout_d;
  logic [ADDR_WIDTH-1:0] timeout_adr_q, timeout_adr_d;
  logic                  cnt_clr, cnt_en, cnt_expired;

  soc_wb_watchdog_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (cnt_expired)
  );

  always_comb begin
    state_d       = state_q;
    s_adr_d       = s_adr_q;
    s_dat_d       = s_dat_q;
    s_sel_d       = s_sel_q;
    s_we_d        = s_we_q;
    s_req_d       = s_req_q;
    m_dat_d       = m_dat_q;
    m_ack_d       = 1'b0;
    m_err_d       = 1'b0;
    m_rty_d       = 1'b0;
    timeout_d     = 1'b0;
    timeout_adr_d = timeout_adr_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (m.cyc && m.stb) begin
          s_adr_d = m.adr;
          s_dat_d = m.wdat;
          s_sel_d = m.sel;
          s_we_d  = m.we;
          s_req_d = 1'b1;
          cnt_clr = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // A master abort outranks any slave response arriving in the same cycle.
        if (!m.cyc) begin
          s_req_d = 1'b0;
          state_d = IDLE;
        end else if (s.err) begin
          s_req_d = 1'b0;
          m_err_d = 1'b1;
          state_d = RESP;
        end else if (s.rty) begin
          s_req_d = 1'b0;
          m_rty_d = 1'b1;
          state_d = RESP;
        end else if (s.ack) begin
          s_req_d = 1'b0;
          m_ack_d = 1'b1;
          if (!s_we_q) begin
            m_dat_d = s.rdat;
          end
          state_d = RESP;
        end else if (cnt_expired) begin
          s_req_d       = 1'b0;
          m_err_d       = 1'b1;
          timeout_d     = 1'b1;
          timeout_adr_d = s_adr_q;
          state_d       = RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        s_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      s_adr_q       <= '0;
      s_dat_q       <= '0;
      s_sel_q       <= '0;
      s_we_q        <= 1'b0;
      s_req_q       <= 1'b0;
      m_dat_q       <= '0;
      m_ack_q       <= 1'b0;
      m_err_q       <= 1'b0;
      m_rty_q       <= 1'b0;
      timeout_q     <= 1'b0;
      timeout_adr_q <= '0;
    end else begin
      state_q       <= state_d;
      s_adr_q       <= s_adr_d;
      s_dat_q       <= s_dat_d;
      s_sel_q       <= s_sel_d;
      s_we_q        <= s_we_d;
      s_req_q       <= s_req_d;
      m_dat_q       <= m_dat_d;
      m_ack_q       <= m_ack_d;
      m_err_q       <= m_err_d;
      m_rty_q       <= m_rty_d;
      timeout_q     <= timeout_d;
      timeout_adr_q <= timeout_adr_d;
    end
  end

  assign s.adr  = s_adr_q;
  assign s.wdat = s_dat_q;
  assign s.sel  = s_sel_q;
  assign s.we   = s_we_q;
  assign s.cyc  = s_req_q;
  assign s.stb  = s_req_q;
  assign s.cti  = WB_CTI_CLASSIC;
  assign s.bte  = WB_BTE_LINEAR;

  assign m.rdat = m_dat_q;
  assign m.ack  = m_ack_q;
  assign m.err  = m_err_q;
  assign m.rty  = m_rty_q;

  assign timeout_o     = timeout_q;
  assign timeout_adr_o = timeout_adr_q;

  // Incoming burst hints are deliberately dropped; every beat goes out as a classic cycle.
  logic unused_burst;
  assign unused_burst = ^{m.cti, m.bte, (m.cti == WB_CTI_EOB)};

endmodule

// File: doc/soc_wb_timeout_bridge.md
# soc_wb_timeout_bridge

Registered Wishbone bridge with a bus watchdog, placed directly downstream of the arbitrated bus mux and upstream of the address decoder and slaves. It latches each granted request and replays it to the slave side as a classic single-beat cycle. The slave response is returned to the master registered. If no slave answers within `TIMEOUT` cycles, the bridge terminates the cycle with an error, so a dead or unmapped slave cannot hang the shared bus.

## Interface
- `DATA_WIDTH`, 32, data width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 32, address width in bits.
- `TIMEOUT`, 1024, maximum cycles a request may wait in `REQ`; 0 disables the watchdog.
- `SEL_WIDTH`, local, `DATA_WIDTH>>3`.
- `CNT_WIDTH`, local, `$clog2(TIMEOUT+1)`, minimum 1.
- `clk_i`  in  1  sole clock; all logic on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `m_adr_i`, `m_dat_i`, `m_sel_i`, `m_we_i`, `m_cyc_i`, `m_stb_i`, `m_cti_i`[3], `m_bte_i`[2]  in  request from the mux slave port.
- `m_dat_o`  out  DATA_WIDTH  registered read data.
- `m_ack_o`, `m_err_o`, `m_rty_o`  out  1 each  registered termination; at most one high per cycle.
- `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o`, `s_cyc_o`, `s_stb_o`, `s_cti_o`[3], `s_bte_o`[2]  out  registered request toward decoder/slaves.
- `s_dat_i`, `s_ack_i`, `s_err_i`, `s_rty_i`  in  slave response.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.
- `timeout_adr_o`  out  ADDR_WIDTH  address of the last timed-out request; holds until the next timeout.

## Operation
- States: `IDLE`, `REQ`, `RESP`.
- `IDLE` with `m_cyc_i & m_stb_i`:
  - Capture adr/dat/sel/we into the `s_*` registers.
  - Set `s_cyc_o = s_stb_o = 1`.
  - Clear the counter.
  - Go to `REQ`.
- `s_cti_o` is always `3'b000` and `s_bte_o` is always `2'b00`. Bursts are split into classic beats.
- `REQ`, response priority `err > rty > ack`:
  - On any slave termination, drop `s_cyc_o`/`s_stb_o` and go to `RESP`.
  - Register the matching `m_*_o`.
  - Register `m_dat_o <= s_dat_i` when ack and `!s_we_o`; otherwise keep the previous `m_dat_o`.
- `REQ` with no termination: increment the counter. When the counter equals `TIMEOUT-1` (and `TIMEOUT != 0`):
  - Drop `s_cyc_o`/`s_stb_o`.
  - Register `m_err_o = 1`, pulse `timeout_o`, latch `timeout_adr_o <= s_adr_o`.
  - Go to `RESP`.
- Slave termination in the same cycle as the timeout: the termination wins. No `timeout_o`.
- `REQ` with `m_cyc_i == 0` (master abort):
  - Drop `s_cyc_o`/`s_stb_o`.
  - Go to `IDLE` with no response.
  - A late slave response is ignored.
- `RESP`:
  - Exactly one `m_*_o` is high for this one cycle.
  - The master's still-asserted stb is not re-captured.
  - Next state is unconditionally `IDLE`; all `m_ack/err/rty_o` clear.
- The counter saturates and does not wrap. With `TIMEOUT == 0` it is held at 0.
- Reset (any state, including mid-`REQ`):
  - State goes to `IDLE`.
  - `s_cyc_o`, `s_stb_o`, `m_ack_o`, `m_err_o`, `m_rty_o`, `timeout_o` = 0.
  - `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o`, `m_dat_o`, `timeout_adr_o`, counter = 0.
  - `s_cti_o`/`s_bte_o` = 0.
  - A slave response in the reset cycle is discarded.

## Timing
- All outputs are registered. There is no combinational path from `m_*_i` to `s_*_o`, or from `s_*_i` to `m_*_o`.
- Request seen in `IDLE` at cycle 0 → `s_stb_o` high in cycle 1.
- Slave acks in cycle 1+k (k ≥ 0) → `m_ack_o` high in cycle 2+k → `IDLE` in cycle 3+k.
- Minimum beat period is 3 cycles.
- Timeout case: `REQ` is entered at cycle 1 and the watchdog fires after `TIMEOUT` cycles in `REQ`. `m_err_o` and `timeout_o` are high in cycle `1+TIMEOUT`.
- `timeout_adr_o` is valid from cycle `1+TIMEOUT`.
- Master abort seen in `REQ` at cycle c → `s_cyc_o` low in cycle c+1.

## Structure
- Shared package `soc_wb_pkg`:
  - state enum `wb_bridge_state_t` {`IDLE`, `REQ`, `RESP`};
  - constants `WB_CTI_CLASSIC = 3'b000`, `WB_CTI_EOB = 3'b111`, `WB_BTE_LINEAR = 2'b00`.
- Sub-module `soc_wb_watchdog_cnt`: saturating counter with `clr`/`en` inputs and an `expired` output, parameter `TIMEOUT`. Everything else is in one FSM.

## Test plan
- Read, slave acks with k=0 and data `32'hDEADBEEF` → `m_ack_o` in cycle 2, `m_dat_o == 32'hDEADBEEF`, `s_cti_o == 0`.
- Write, `adr 32'h1000_0040`, `sel 4'b0011`, slave acks after k=5 → `s_adr_o`/`s_sel_o` stable cycles 1–6, `m_ack_o` in cycle 7.
- `TIMEOUT=16`, slave never responds, `adr 32'hF000_0000` → `m_err_o` and `timeout_o` in cycle 17, `timeout_adr_o == 32'hF000_0000`, `s_cyc_o` low in cycle 17.
- `TIMEOUT=16`, `s_ack_i` and `s_err_i` both asserted in the 16th `REQ` cycle → only `m_err_o`, `timeout_o` stays 0.
- Master drops `m_cyc_i` at cycle 3, slave acks at cycle 4 → no `m_*_o` response, bridge `IDLE` at cycle 4.
- `rst_i` asserted in the middle of `REQ` → all outputs 0 in the next cycle; a new request afterwards completes normally.
